// File: rtl/mem_access_ctrl.sv
// Sequential memory-access controller: accepts one ALU/LDR/STR/ADR op per start strobe,
// runs a req/ack RAM handshake with a wait-state timeout and returns a write-back pulse.
module mem_access_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned IMM_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [3:0]            op_code,
  input  logic [DATA_WIDTH-1:0] SR1,
  input  logic [DATA_WIDTH-1:0] SR2,
  input  logic [DATA_WIDTH-1:0] ALU_result,
  input  logic [IMM_WIDTH-1:0]  IV_Mov,
  input  logic [DATA_WIDTH-1:0] RAM_out,
  input  logic                  mem_ack,
  output logic                  mem_req,
  output logic                  RW,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [DATA_WIDTH-1:0] RAM_in,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  reg_write,
  output logic                  busy,
  output logic                  done,
  output logic                  bus_error
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] OpAdr = 4'b1100;
  localparam logic [3:0] OpLdr = 4'b1101;
  localparam logic [3:0] OpStr = 4'b1110;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q;
  logic [3:0]      op_q;
  logic [CntW-1:0] cnt_q;
  logic            is_mem_op;

  assign is_mem_op = (op_code == OpAdr) || (op_code == OpLdr) || (op_code == OpStr);

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      op_q        <= '0;
      cnt_q       <= '0;
      mem_req     <= 1'b0;
      RW          <= 1'b0;
      address_out <= '0;
      RAM_in      <= '0;
      reg_data    <= '0;
      reg_write   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            op_q  <= op_code;
            cnt_q <= '0;
            if (is_mem_op) begin
              state_q     <= StAccess;
              mem_req     <= 1'b1;
              busy        <= 1'b1;
              RW          <= (op_code == OpLdr);
              address_out <= ADDR_WIDTH'(SR1);
              // ADR stores the immediate; RAM_in doubles as its holding register
              RAM_in      <= (op_code == OpStr) ? SR2 : DATA_WIDTH'(IV_Mov);
            end else begin
              state_q   <= StDone;
              reg_data  <= ALU_result;
              reg_write <= 1'b1;
              done      <= 1'b1;
            end
          end
        end
        StAccess: begin
          if (mem_ack) begin
            state_q <= StDone;
            mem_req <= 1'b0;
            RW      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            cnt_q   <= '0;
            if (op_q == OpLdr) begin
              reg_data  <= RAM_out;
              reg_write <= 1'b1;
            end else if (op_q == OpAdr) begin
              reg_data  <= RAM_in;
              reg_write <= 1'b1;
            end
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            state_q   <= StDone;
            mem_req   <= 1'b0;
            RW        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            bus_error <= 1'b1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          done      <= 1'b0;
          reg_write <= 1'b0;
          bus_error <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected accesses/completions,
// a negedge monitor pops and compares whenever mem_req or done is presented.
module tb_mem_access_ctrl;

  localparam int TO = 15;
  localparam logic [3:0] OpAlu = 4'b0000;
  localparam logic [3:0] OpAdr = 4'b1100;
  localparam logic [3:0] OpLdr = 4'b1101;
  localparam logic [3:0] OpStr = 4'b1110;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op_code = '0;
  logic [31:0] SR1 = '0, SR2 = '0, ALU_result = '0, RAM_out = '0;
  logic [15:0] IV_Mov = '0;
  logic        mem_ack = 1'b0;
  logic        mem_req, RW, reg_write, busy, done, bus_error;
  logic [31:0] address_out, RAM_in, reg_data;

  mem_access_ctrl #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .IMM_WIDTH(16), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .Reset(Reset), .start(start), .op_code(op_code), .SR1(SR1), .SR2(SR2),
    .ALU_result(ALU_result), .IV_Mov(IV_Mov), .RAM_out(RAM_out), .mem_ack(mem_ack),
    .mem_req(mem_req), .RW(RW), .address_out(address_out), .RAM_in(RAM_in),
    .reg_data(reg_data), .reg_write(reg_write), .busy(busy), .done(done),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; logic wr; logic err; int cyc; } resp_t;
  typedef struct { logic rw; logic [31:0] addr; logic [31:0] wd; logic chk_wd; int len; } acc_t;

  resp_t rq[$];
  acc_t  aq[$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor
  bit    req_prev = 1'b0;
  int    req_len = 0;
  acc_t  cur;
  resp_t r;
  always @(negedge clk) begin
    if (started) begin
      chk("strobe_align", {63'b0, reg_write & ~done}, 64'd0);
      chk("busy_vs_req", {63'b0, busy}, {63'b0, mem_req});
      if (done) begin
        if (rq.size() == 0) note_fail("unexpected_done");
        else begin
          r = rq.pop_front();
          chk("reg_data", {32'b0, reg_data}, {32'b0, r.data});
          chk("reg_write", {63'b0, reg_write}, {63'b0, r.wr});
          chk("bus_error", {63'b0, bus_error}, {63'b0, r.err});
          chk("done_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
      if (mem_req) begin
        if (!req_prev) begin
          req_len = 0;
          if (aq.size() == 0) begin
            note_fail("unexpected_mem_req");
            cur = '{rw: RW, addr: address_out, wd: RAM_in, chk_wd: 1'b0, len: -1};
          end else cur = aq.pop_front();
        end
        req_len++;
        chk("rw", {63'b0, RW}, {63'b0, cur.rw});
        chk("address_out", {32'b0, address_out}, {32'b0, cur.addr});
        if (cur.chk_wd) chk("ram_in", {32'b0, RAM_in}, {32'b0, cur.wd});
      end else if (req_prev) begin
        chk("req_len", 64'(req_len), 64'(cur.len));
      end
      req_prev = mem_req;
    end
  end

  // Caller is at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic issue(input logic [3:0] op, input logic [31:0] sr1, input logic [31:0] sr2,
                       input logic [31:0] alu, input logic [15:0] iv, input logic [31:0] ram,
                       input int ack_at, input logic [31:0] exp_data, input logic exp_wr,
                       input logic exp_err);
    bit is_mem;
    int len;
    int acc;
    is_mem = (op == OpAdr) || (op == OpLdr) || (op == OpStr);
    len = (ack_at == 0) ? TO : ack_at;
    op_code = op; SR1 = sr1; SR2 = sr2; ALU_result = alu; IV_Mov = iv; start = 1'b1;
    acc = cyc + 1;
    rq.push_back('{data: exp_data, wr: exp_wr, err: exp_err, cyc: is_mem ? acc + len : acc});
    if (is_mem)
      aq.push_back('{rw: (op == OpLdr), addr: sr1, wd: (op == OpStr) ? sr2 : {16'b0, iv},
                     chk_wd: (op != OpLdr), len: len});
    @(negedge clk);
    // Scramble operands: the DUT must use its registered copies
    start = 1'b0; op_code = OpAlu; SR1 = ~sr1; SR2 = $urandom; ALU_result = $urandom;
    IV_Mov = 16'($urandom);
    if (is_mem) begin
      for (int k = 1; k <= TO; k++) begin
        if (k == ack_at) begin mem_ack = 1'b1; RAM_out = ram; end
        if (k == 2) start = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0; start = 1'b0; RAM_out = $urandom;
        if (k == ack_at) break;
      end
    end
    // DONE cycle: start and a stray ack must both be ignored
    start = 1'b1; mem_ack = 1'b1;
    @(negedge clk);
    start = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("rst_rw", {63'b0, RW}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_reg_write", {63'b0, reg_write}, 64'd0);
    chk("rst_bus_error", {63'b0, bus_error}, 64'd0);
    chk("rst_reg_data", {32'b0, reg_data}, 64'd0);
    chk("rst_address", {32'b0, address_out}, 64'd0);
    chk("rst_ram_in", {32'b0, RAM_in}, 64'd0);
    Reset = 1'b0;
    started = 1'b1;

    issue(OpAlu, 32'h5, 32'h6, 32'h0000_00AA, 16'h1, 32'h0, 0, 32'h0000_00AA, 1'b1, 1'b0);
    issue(OpStr, 32'h10, 32'hDEAD_BEEF, 32'h0, 16'h2, 32'h0, 3, 32'h0000_00AA, 1'b0, 1'b0);
    issue(OpLdr, 32'h20, 32'h0, 32'h0, 16'h3, 32'h1234_5678, 1, 32'h1234_5678, 1'b1, 1'b0);
    issue(OpAdr, 32'h30, 32'h0, 32'h0, 16'hBEEF, 32'h0, 2, 32'h0000_BEEF, 1'b1, 1'b0);
    issue(OpLdr, 32'h60, 32'h0, 32'h0, 16'h4, 32'h0, 0, 32'h0000_BEEF, 1'b0, 1'b1);
    issue(OpLdr, 32'h64, 32'h0, 32'h0, 16'h5, 32'hCAFE_F00D, TO, 32'hCAFE_F00D, 1'b1, 1'b0);

    // Reset in the middle of an access, with a start pulse while busy
    op_code = OpLdr; SR1 = 32'h50; start = 1'b1;
    aq.push_back('{rw: 1'b1, addr: 32'h50, wd: 32'h0, chk_wd: 1'b0, len: 3});
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; op_code = OpAlu; ALU_result = 32'h99;
    @(negedge clk);
    start = 1'b0; Reset = 1'b1;
    @(negedge clk);
    chk("midrst_mem_req", {63'b0, mem_req}, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_rw", {63'b0, RW}, 64'd0);
    chk("midrst_reg_data", {32'b0, reg_data}, 64'd0);
    chk("midrst_address", {32'b0, address_out}, 64'd0);
    Reset = 1'b0;

    issue(OpAlu, 32'h0, 32'h0, 32'h0000_0077, 16'h0, 32'h0, 0, 32'h0000_0077, 1'b1, 1'b0);

    repeat (4) @(negedge clk);
    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    chk("access_queue_empty", 64'(aq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
